// File: rtl/wb_regfile_if.sv
// MEM/WB-to-regfile signal bundle: WB-stage write-back inputs, ID-stage read ports,
// debug read port and the retire counter.
interface wb_regfile_if;
    logic        ValidW;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic        LinkW;
    logic [4:0]  WriteRegW;
    logic [31:0] ALUOutW;
    logic [31:0] ReadDataW;
    logic [31:0] PCplus4W;
    logic [4:0]  RsD;
    logic [4:0]  RtD;
    logic [4:0]  DbgAddr;
    logic [31:0] ResultW;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] DbgData;
    logic [31:0] RetireCount;

    modport master (
        output ValidW, RegWriteW, MemtoRegW, LinkW, WriteRegW,
        output ALUOutW, ReadDataW, PCplus4W, RsD, RtD, DbgAddr,
        input  ResultW, RD1D, RD2D, DbgData, RetireCount
    );

    modport slave (
        input  ValidW, RegWriteW, MemtoRegW, LinkW, WriteRegW,
        input  ALUOutW, ReadDataW, PCplus4W, RsD, RtD, DbgAddr,
        output ResultW, RD1D, RD2D, DbgData, RetireCount
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage plus 32x32 architectural register file: result select, commit,
// two bypassed ID read ports, an unbypassed debug port and a retired-instruction counter.
module wb_regfile #(
    parameter logic [31:0] SP_INIT = 32'h0000_0FFC,
    parameter bit          BYPASS  = 1'b1
) (
    input logic         CLOCK,
    input logic         RESET_N,
    wb_regfile_if.slave wb
);
    logic [31:0] regs [0:31];
    logic [31:0] result;
    logic        commit;
    logic [31:0] retire_cnt;

    always_comb begin
        if (wb.LinkW)
            result = wb.PCplus4W;
        else if (wb.MemtoRegW)
            result = wb.ReadDataW;
        else
            result = wb.ALUOutW;
    end

    // Gating with RESET_N keeps the bypass path from leaking a write that reset will discard.
    assign commit = RESET_N & wb.ValidW & wb.RegWriteW & (wb.WriteRegW != 5'd0);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= (i == 29) ? SP_INIT : 32'd0;
        end else if (commit) begin
            regs[wb.WriteRegW] <= result;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)
            retire_cnt <= 32'd0;
        else if (wb.ValidW)
            retire_cnt <= retire_cnt + 32'd1;
    end

    always_comb begin
        if (wb.RsD == 5'd0)
            wb.RD1D = 32'd0;
        else if (BYPASS && commit && (wb.RsD == wb.WriteRegW))
            wb.RD1D = result;
        else
            wb.RD1D = regs[wb.RsD];
    end

    always_comb begin
        if (wb.RtD == 5'd0)
            wb.RD2D = 32'd0;
        else if (BYPASS && commit && (wb.RtD == wb.WriteRegW))
            wb.RD2D = result;
        else
            wb.RD2D = regs[wb.RtD];
    end

    // Debug port shows committed state only, so it lags the ID ports by one edge on a write.
    always_comb begin
        if (wb.DbgAddr == 5'd0)
            wb.DbgData = 32'd0;
        else
            wb.DbgData = regs[wb.DbgAddr];
    end

    assign wb.ResultW     = result;
    assign wb.RetireCount = retire_cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios plus random traffic against an array model,
// driving a BYPASS=1 and a BYPASS=0 instance from the same stimulus.
module tb_wb_regfile;
    logic CLOCK;
    logic RESET_N;
    int   tests;
    int   fails;
    bit   chk_en;

    wb_regfile_if wbi ();
    wb_regfile_if wbi0 ();

    assign wbi0.ValidW    = wbi.ValidW;
    assign wbi0.RegWriteW = wbi.RegWriteW;
    assign wbi0.MemtoRegW = wbi.MemtoRegW;
    assign wbi0.LinkW     = wbi.LinkW;
    assign wbi0.WriteRegW = wbi.WriteRegW;
    assign wbi0.ALUOutW   = wbi.ALUOutW;
    assign wbi0.ReadDataW = wbi.ReadDataW;
    assign wbi0.PCplus4W  = wbi.PCplus4W;
    assign wbi0.RsD       = wbi.RsD;
    assign wbi0.RtD       = wbi.RtD;
    assign wbi0.DbgAddr   = wbi.DbgAddr;

    wb_regfile #(.SP_INIT(32'h0000_0FFC), .BYPASS(1'b1)) dut1 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .wb(wbi)
    );
    wb_regfile #(.SP_INIT(32'h0000_0FFC), .BYPASS(1'b0)) dut0 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .wb(wbi0)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // Reference model: plain array of architectural values and a retire tally.
    logic [31:0] mregs [32];
    logic [31:0] mcount;
    logic [31:0] cnt_offset;

    function automatic logic [31:0] m_result();
        if (wbi.LinkW)     return wbi.PCplus4W;
        if (wbi.MemtoRegW) return wbi.ReadDataW;
        return wbi.ALUOutW;
    endfunction

    function automatic bit m_commit();
        return RESET_N && wbi.ValidW && wbi.RegWriteW && (wbi.WriteRegW != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] addr, input bit byp);
        if (addr == 5'd0) return 32'd0;
        if (byp && m_commit() && addr == wbi.WriteRegW) return m_result();
        return mregs[addr];
    endfunction

    always @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            mregs[29] = 32'h0000_0FFC;
            mcount = 32'd0;
        end else begin
            if (m_commit()) mregs[wbi.WriteRegW] = m_result();
            if (wbi.ValidW) mcount = mcount + 32'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLOCK) begin
        if (chk_en) begin
            chk("ResultW",     wbi.ResultW,      m_result());
            chk("ResultW_nb",  wbi0.ResultW,     m_result());
            chk("RD1D",        wbi.RD1D,         m_read(wbi.RsD, 1'b1));
            chk("RD2D",        wbi.RD2D,         m_read(wbi.RtD, 1'b1));
            chk("RD1D_nb",     wbi0.RD1D,        m_read(wbi.RsD, 1'b0));
            chk("RD2D_nb",     wbi0.RD2D,        m_read(wbi.RtD, 1'b0));
            chk("DbgData",     wbi.DbgData,      m_read(wbi.DbgAddr, 1'b0));
            chk("DbgData_nb",  wbi0.DbgData,     m_read(wbi.DbgAddr, 1'b0));
            chk("RetireCount", wbi.RetireCount,  mcount + cnt_offset);
            chk("RetireCnt_nb", wbi0.RetireCount, mcount + cnt_offset);
        end
    end

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic drive(input bit v, input bit rw, input bit m, input bit l,
                         input logic [4:0] w, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [31:0] pc);
        wbi.ValidW    = v;
        wbi.RegWriteW = rw;
        wbi.MemtoRegW = m;
        wbi.LinkW     = l;
        wbi.WriteRegW = w;
        wbi.ALUOutW   = alu;
        wbi.ReadDataW = rd;
        wbi.PCplus4W  = pc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        chk_en     = 1'b0;
        cnt_offset = 32'd0;
        RESET_N    = 1'b1;
        idle();
        wbi.RsD     = 5'd29;
        wbi.RtD     = 5'd5;
        wbi.DbgAddr = 5'd29;

        // Reset with no clock edge in between
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_rd1",    wbi.RD1D,         32'h0000_0FFC);
        chk("rst_rd2",    wbi.RD2D,         32'd0);
        chk("rst_cnt",    wbi.RetireCount,  32'd0);
        chk("rst_dbg",    wbi.DbgData,      32'h0000_0FFC);
        chk("rst_rd1_nb", wbi0.RD1D,        32'h0000_0FFC);
        chk_en = 1'b1;

        // Commit and count are ignored while reset is held
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'hABC, 32'd0, 32'd0);
        step();
        step();
        chk("rst_hold_cnt", wbi.RetireCount, 32'd0);
        chk("rst_hold_r5",  wbi.RD2D,        32'd0);
        idle();
        RESET_N = 1'b1;

        // Result mux priority
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 32'h11, 32'h22, 32'h400);
        step();
        wbi.LinkW = 1'b0;
        wbi.WriteRegW = 5'd9;
        step();
        wbi.MemtoRegW = 1'b0;
        wbi.WriteRegW = 5'd10;
        step();
        idle();
        wbi.DbgAddr = 5'd8;
        #1 chk("mux_link", wbi.DbgData, 32'h400);
        wbi.DbgAddr = 5'd9;
        #1 chk("mux_mem",  wbi.DbgData, 32'h22);
        wbi.DbgAddr = 5'd10;
        #1 chk("mux_alu",  wbi.DbgData, 32'h11);
        chk("mux_cnt", wbi.RetireCount, 32'd3);

        // Same-cycle bypass vs. stored value
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'hDEAD_BEEF, 32'd0, 32'd0);
        wbi.RsD = 5'd3;
        wbi.RtD = 5'd3;
        wbi.DbgAddr = 5'd3;
        #1;
        chk("byp_rd1",    wbi.RD1D,    32'hDEAD_BEEF);
        chk("byp_rd2",    wbi.RD2D,    32'hDEAD_BEEF);
        chk("byp_dbg",    wbi.DbgData, 32'd0);
        chk("nobyp_rd1",  wbi0.RD1D,   32'd0);
        chk("nobyp_rd2",  wbi0.RD2D,   32'd0);
        step();
        idle();
        #1;
        chk("byp_post_dbg",   wbi.DbgData, 32'hDEAD_BEEF);
        chk("nobyp_post_rd1", wbi0.RD1D,   32'hDEAD_BEEF);
        chk("byp_post_rd2",   wbi.RD2D,    32'hDEAD_BEEF);

        // $zero is never written
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
        wbi.RsD = 5'd0;
        wbi.RtD = 5'd0;
        #1;
        chk("zero_rd1",    wbi.RD1D,    32'd0);
        chk("zero_rd1_nb", wbi0.RD1D,   32'd0);
        chk("zero_result", wbi.ResultW, 32'hFFFF_FFFF);
        step();
        idle();
        wbi.DbgAddr = 5'd0;
        #1;
        chk("zero_after_rd1", wbi.RD1D,    32'd0);
        chk("zero_after_dbg", wbi.DbgData, 32'd0);

        // Squashed bubble with RegWriteW set
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 32'h1234, 32'd0, 32'd0);
        wbi.RsD = 5'd4;
        wbi.DbgAddr = 5'd4;
        #1 chk("bub_rd1", wbi.RD1D, 32'd0);
        step();
        idle();
        #1;
        chk("bub_reg4", wbi.DbgData,     32'd0);
        chk("bub_cnt",  wbi.RetireCount, 32'd5);

        // Random traffic with occasional asynchronous reset pulses
        for (int n = 0; n < 600; n++) begin
            step();
            drive(($urandom_range(3) != 0), ($urandom_range(9) < 7),
                  $urandom_range(1) == 1, ($urandom_range(5) == 0),
                  5'($urandom_range(31)), $urandom, $urandom, $urandom);
            wbi.RsD     = ($urandom_range(2) == 0) ? wbi.WriteRegW : 5'($urandom_range(31));
            wbi.RtD     = ($urandom_range(3) == 0) ? wbi.RsD : 5'($urandom_range(31));
            wbi.DbgAddr = ($urandom_range(2) == 0) ? wbi.WriteRegW : 5'($urandom_range(31));
            if ($urandom_range(79) == 0) begin
                #1 RESET_N = 1'b0;
                #1 RESET_N = 1'b1;
            end
        end

        // Counter wrap
        step();
        idle();
        force dut1.retire_cnt = 32'hFFFF_FFFE;
        force dut0.retire_cnt = 32'hFFFF_FFFE;
        cnt_offset = 32'hFFFF_FFFE - mcount;
        #1;
        release dut1.retire_cnt;
        release dut0.retire_cnt;
        #1 chk("wrap_pre", wbi.RetireCount, 32'hFFFF_FFFE);
        wbi.ValidW = 1'b1;
        step();
        chk("wrap_ffff", wbi.RetireCount, 32'hFFFF_FFFF);
        step();
        chk("wrap_zero", wbi.RetireCount, 32'd0);
        step();
        chk("wrap_one",  wbi.RetireCount, 32'd1);
        idle();
        step();
        chk("wrap_hold", wbi.RetireCount, 32'd1);

        // Reset coincident with a commit
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h55, 32'd0, 32'd0);
        wbi.RsD = 5'd7;
        wbi.DbgAddr = 5'd7;
        #2;
        RESET_N = 1'b0;
        cnt_offset = 32'd0;
        #1;
        chk("rstw_rd1", wbi.RD1D,        32'd0);
        chk("rstw_dbg", wbi.DbgData,     32'd0);
        chk("rstw_cnt", wbi.RetireCount, 32'd0);
        step();
        chk("rstw_edge_r7", wbi.DbgData, 32'd0);
        idle();
        RESET_N = 1'b1;
        #1;
        chk("rstw_rel_r7",  wbi.DbgData,     32'd0);
        chk("rstw_rel_cnt", wbi.RetireCount, 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h77, 32'd0, 32'd0);
        step();
        idle();
        #1;
        chk("rstw_first_r7",  wbi.DbgData,     32'h77);
        chk("rstw_first_cnt", wbi.RetireCount, 32'd1);

        step();
        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
